// File: rtl/tuning_sequencer.sv
// tuning_sequencer
//   Schedules pitch measurement between get_period and note_display. While
//   start_tuning is high it collects 2**LOG2_N plausible period samples,
//   averages them and presents one registered result, holds it for
//   HOLD_CYCLES, then re-arms. An acquisition that does not complete within
//   TIMEOUT_CYCLES reports period 0 with no_signal set so the display blanks.
//
//   Optional feature macro: OUTLIER_REJECT_EN (adds reference-based outlier
//   rejection on top of the range check).
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   start_tuning  level; 1 = measure, 0 = stop and idle
//   period_in     raw period sample (PW bits)
//   period_valid  1-cycle strobe qualifying period_in
//   period_out    averaged period, registered
//   result_valid  1-cycle strobe when period_out updates
//   no_signal     1 = last result came from a timeout
//   busy          1 while acquiring
//   reject_cnt    saturating count of rejected samples since reset
module tuning_sequencer #(
    parameter int unsigned PW             = 34,
    parameter int unsigned LOG2_N         = 3,
    parameter int unsigned MIN_PERIOD     = 5000000,
    parameter int unsigned MAX_PERIOD     = 30000000,
    parameter int unsigned TIMEOUT_CYCLES = 100000000,
    parameter int unsigned HOLD_CYCLES    = 25000000,
    parameter int unsigned TOL_SHIFT      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_tuning,
    input  logic [PW-1:0] period_in,
    input  logic          period_valid,
    output logic [PW-1:0] period_out,
    output logic          result_valid,
    output logic          no_signal,
    output logic          busy,
    output logic [7:0]    reject_cnt
);

    localparam int unsigned SW   = PW + LOG2_N;
    localparam int unsigned CW   = LOG2_N + 1;
    localparam int unsigned TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQUIRE,
        S_DONE,
        S_TIMEOUT,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pout_q, pout_d;
    logic          rv_q, rv_d;
    logic          ns_q, ns_d;
    logic [7:0]    rej_q, rej_d;

    logic          in_range;
    logic          take;
    logic          reject;
    logic [SW-1:0] new_sum;
    logic [CW-1:0] new_cnt;

`ifdef OUTLIER_REJECT_EN
    logic [PW-1:0] ref_q, ref_d;
    logic [2:0]    run_q, run_d;   // consecutive outliers, stops at 4
    logic [PW-1:0] dev;
`endif

    assign in_range = (period_in >= PW'(MIN_PERIOD)) && (period_in <= PW'(MAX_PERIOD));

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        pout_d  = pout_q;
        rv_d    = 1'b0;
        ns_d    = ns_q;
        rej_d   = rej_q;
        take    = 1'b0;
        reject  = 1'b0;
        new_sum = sum_q + SW'(period_in);
        new_cnt = cnt_q + CW'(1);
`ifdef OUTLIER_REJECT_EN
        ref_d   = ref_q;
        run_d   = run_q;
        dev     = (period_in > ref_q) ? (period_in - ref_q) : (ref_q - period_in);
`endif

        if (state_q != S_IDLE && !start_tuning) begin
            // Stopping wins over everything, including a sample strobed this cycle.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_tuning) begin
                        state_d = S_ACQUIRE;
                        sum_d   = '0;
                        cnt_d   = '0;
                        timer_d = '0;
                    end
                end
                S_ACQUIRE: begin
                    timer_d = timer_q + TW'(1);
                    if (period_valid) begin
                        if (!in_range) begin
                            reject = 1'b1;
`ifdef OUTLIER_REJECT_EN
                        end else if (cnt_q == '0 || run_q == 3'd4) begin
                            // First sample, or restart after a run of outliers.
                            take    = 1'b1;
                            new_sum = SW'(period_in);
                            new_cnt = CW'(1);
                            ref_d   = period_in;
                            run_d   = '0;
                        end else if (dev > (ref_q >> TOL_SHIFT)) begin
                            reject = 1'b1;
                            run_d  = run_q + 3'd1;
                        end else begin
                            take  = 1'b1;
                            run_d = '0;
`else
                        end else begin
                            take = 1'b1;
`endif
                        end
                    end
                    if (reject && rej_q != '1) begin
                        rej_d = rej_q + 8'd1;
                    end
                    if (take) begin
                        sum_d = new_sum;
                        cnt_d = new_cnt;
                    end
                    // The result is registered here so it appears one cycle after the
                    // final strobe; DONE/TIMEOUT are the cycles the strobe is visible.
                    if (take && new_cnt == CW'(1 << LOG2_N)) begin
                        state_d = S_DONE;
                        pout_d  = PW'(new_sum >> LOG2_N);
                        rv_d    = 1'b1;
                        ns_d    = 1'b0;
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_TIMEOUT;
                        pout_d  = '0;
                        rv_d    = 1'b1;
                        ns_d    = 1'b1;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    state_d = S_HOLD;
                    timer_d = '0;
                end
                S_HOLD: begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                        state_d = S_ACQUIRE;
                        sum_d   = '0;
                        cnt_d   = '0;
                        timer_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef OUTLIER_REJECT_EN
        if (state_d == S_ACQUIRE && state_q != S_ACQUIRE) begin
            run_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            pout_q  <= '0;
            rv_q    <= 1'b0;
            ns_q    <= 1'b1;
            rej_q   <= '0;
`ifdef OUTLIER_REJECT_EN
            ref_q   <= '0;
            run_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            pout_q  <= pout_d;
            rv_q    <= rv_d;
            ns_q    <= ns_d;
            rej_q   <= rej_d;
`ifdef OUTLIER_REJECT_EN
            ref_q   <= ref_d;
            run_q   <= run_d;
`endif
        end
    end

    assign period_out   = pout_q;
    assign result_valid = rv_q;
    assign no_signal    = ns_q;
    assign busy         = (state_q == S_ACQUIRE);
    assign reject_cnt   = rej_q;

endmodule
